tl_a_repeater: RTL

Single-entry TileLink A-channel repeater placed directly upstream of the A-channel monitor wrapper. It forwards requests from an upstream master to a downstream port. When the consumer asserts `repeat` on the cycle a request is accepted, the block captures that request and re-presents it on later cycles without asking upstream for a new one. Typical users are width/fragment adapters that must issue one request several times. All downstream-side signals (valid, ready, fields, `full`) feed the monitor unchanged.

---
 rtl/tl_a_repeater.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tl_a_repeater.sv
// rtl/tl_a_repeater.sv - single-entry TileLink A-channel repeater with capture/re-issue
module tl_a_repeater #(
    parameter int ADDR_W   = 30,
    parameter int SOURCE_W = 7,
    parameter int SIZE_W   = 4,
    parameter int MASK_W   = 8,
    parameter int DATA_W   = 64,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                do_repeat,

    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [2:0]          enq_opcode,
    input  logic [2:0]          enq_param,
    input  logic [SIZE_W-1:0]   enq_size,
    input  logic [SOURCE_W-1:0] enq_source,
    input  logic [ADDR_W-1:0]   enq_address,
    input  logic [MASK_W-1:0]   enq_mask,
    input  logic [DATA_W-1:0]   enq_data,
    input  logic                enq_corrupt,

    output logic                deq_valid,
    input  logic                deq_ready,
    output logic [2:0]          deq_opcode,
    output logic [2:0]          deq_param,
    output logic [SIZE_W-1:0]   deq_size,
    output logic [SOURCE_W-1:0] deq_source,
    output logic [ADDR_W-1:0]   deq_address,
    output logic [MASK_W-1:0]   deq_mask,
    output logic [DATA_W-1:0]   deq_data,
    output logic                deq_corrupt,

    output logic                full,
    output logic [CNT_W-1:0]    repeat_count,
    output logic                repeat_err
);

    localparam int          LG_MASK   = $clog2(MASK_W);
    localparam logic [2:0]  OP_GET    = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]          saved_opcode;
    logic [2:0]          saved_param;
    logic [SIZE_W-1:0]   saved_size;
    logic [SOURCE_W-1:0] saved_source;
    logic [ADDR_W-1:0]   saved_address;
    logic [MASK_W-1:0]   saved_mask;
    logic [DATA_W-1:0]   saved_data;
    logic                saved_corrupt;

    logic [CNT_W-1:0]    count_q;
    logic                err_q;
    logic                fire;
    logic                oversize_get;

    assign full      = (state_q == HOLD);
    assign deq_valid = enq_valid | full;
    // Upstream is stalled while a beat is held so it is never consumed twice.
    assign enq_ready = deq_ready & ~full;
    assign fire      = deq_valid & deq_ready;

    assign deq_opcode  = full ? saved_opcode  : enq_opcode;
    assign deq_param   = full ? saved_param   : enq_param;
    assign deq_size    = full ? saved_size    : enq_size;
    assign deq_source  = full ? saved_source  : enq_source;
    assign deq_address = full ? saved_address : enq_address;
    assign deq_mask    = full ? saved_mask    : enq_mask;
    assign deq_data    = full ? saved_data    : enq_data;
    assign deq_corrupt = full ? saved_corrupt : enq_corrupt;

    assign oversize_get = (deq_opcode == OP_GET) && (deq_size > SIZE_W'(LG_MASK));

    assign repeat_count = count_q;
    assign repeat_err   = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS: if (fire && do_repeat)  state_d = HOLD;
            HOLD: if (fire && !do_repeat) state_d = PASS;
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            saved_opcode  <= '0;
            saved_param   <= '0;
            saved_size    <= '0;
            saved_source  <= '0;
            saved_address <= '0;
            saved_mask    <= '0;
            saved_data    <= '0;
            saved_corrupt <= 1'b0;
            count_q       <= '0;
            err_q         <= 1'b0;
        end else if (fire) begin
            if (do_repeat) begin
                if (!full) begin
                    saved_opcode  <= enq_opcode;
                    saved_param   <= enq_param;
                    saved_size    <= enq_size;
                    saved_source  <= enq_source;
                    saved_address <= enq_address;
                    saved_mask    <= enq_mask;
                    saved_data    <= enq_data;
                    saved_corrupt <= enq_corrupt;
                    count_q       <= CNT_W'(1);
                end else if (count_q != CNT_MAX) begin
                    count_q <= count_q + CNT_W'(1);
                end
                // A Get wider than the data bus cannot be re-issued as-is.
                if (oversize_get) begin
                    err_q <= 1'b1;
                end
            end else begin
                count_q <= '0;
            end
        end
    end

endmodule
